// File: rtl/lu_result_fifo.sv
// ---------------------------------------------------------------------------
// lu_result_fifo
//
// Purpose:
//   Small first-word-fall-through FIFO that buffers logic-unit results
//   ({answer, opcode}) between the logic unit and its consumer. The FIFO can
//   optionally store a zero flag and a sign flag per entry. Both flags are
//   computed when the entry is pushed.
//
// Configuration macro:
//   LU_RESULT_FLAGS_EN
//     defined   -> per-entry zero/sign flags are stored and driven on
//                  out_zero/out_sign.
//     undefined -> no flag storage is built, and out_zero/out_sign are tied
//                  to 0.
//
// Parameters:
//   DEPTH   number of entries (power of two, >= 2)
//   DATA_W  width of the result word
//
// Ports:
//   clk        in   clock; all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset; discards all entries
//   in_valid   in   upstream presents a result this cycle
//   in_ans     in   result word             [DATA_W]
//   in_opt     in   opcode for the result   [3]
//   in_ready   out  FIFO can accept a push (not full)
//   out_valid  out  head entry is valid (not empty)
//   out_ready  in   consumer takes the head entry this cycle
//   out_ans    out  head result word        [DATA_W]
//   out_opt    out  head opcode             [3]
//   out_zero   out  head result equals zero
//   out_sign   out  head result MSB
//   count      out  number of stored entries [$clog2(DEPTH)+1]
// ---------------------------------------------------------------------------
module lu_result_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_ans,
    input  logic [2:0]                 in_opt,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_ans,
    output logic [2:0]                 out_opt,
    output logic                       out_zero,
    output logic                       out_sign,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0] COUNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_EMPTY = {CW{1'b0}};
    localparam logic [CW-1:0] COUNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);

    // Entry storage. Memory contents are not reset. Only the pointers and
    // the count define which entries are valid.
    logic [DATA_W-1:0] mem_ans_q [DEPTH];
    logic [2:0]        mem_opt_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic push_s;
    logic pop_s;
    logic full_s;
    logic empty_s;

    // Full/empty come only from the registered count. As a result, a pop in
    // the same cycle never opens a slot for a push on a full FIFO.
    assign full_s    = (count_q == COUNT_FULL);
    assign empty_s   = (count_q == COUNT_EMPTY);
    assign in_ready  = ~full_s;
    assign out_valid = ~empty_s;
    assign push_s    = in_valid  & ~full_s;
    assign pop_s     = out_ready & ~empty_s;
    assign count     = count_q;

    assign out_ans = mem_ans_q[rd_ptr_q];
    assign out_opt = mem_opt_q[rd_ptr_q];

    // Next-state logic for the pointers and the occupancy count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // The pointers are exactly AW bits wide, and DEPTH is a power of
        // two. The increment therefore wraps DEPTH-1 -> 0 naturally.
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry write port. The resident entries stay untouched until the write
    // pointer comes back around to them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_ans_q[wr_ptr_q] <= in_ans;
            mem_opt_q[wr_ptr_q] <= in_opt;
        end
    end

`ifdef LU_RESULT_FLAGS_EN
    // Flag pair is {zero, sign}, derived from the result word.
    function automatic logic [1:0] calc_flags(input logic [DATA_W-1:0] ans);
        logic [1:0] f;
        f[1] = (ans == {DATA_W{1'b0}});
        f[0] = ans[DATA_W-1];
        return f;
    endfunction

    logic [1:0] mem_flags_q [DEPTH];

    // Flag write port. The flags are captured at push time alongside the data.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_flags_q[wr_ptr_q] <= calc_flags(in_ans);
        end
    end

    assign out_zero = mem_flags_q[rd_ptr_q][1];
    assign out_sign = mem_flags_q[rd_ptr_q][0];
`else
    assign out_zero = 1'b0;
    assign out_sign = 1'b0;
`endif

endmodule

// File: tb/tb_lu_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_lu_result_fifo
//
// Directed testbench for lu_result_fifo with DEPTH=4 and DATA_W=32.
//   - Inputs are driven 1 ns after the rising edge.
//   - Outputs are sampled at the same point, after the state has settled.
//   - Expected flag values follow LU_RESULT_FLAGS_EN.
// ---------------------------------------------------------------------------
module tb_lu_result_fifo;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_ans;
    logic [2:0]        in_opt;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_ans;
    logic [2:0]        out_opt;
    logic              out_zero;
    logic              out_sign;
    logic [2:0]        count;

    int n_tests;
    int n_fail;

    lu_result_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ans    (in_ans),
        .in_opt    (in_opt),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ans   (out_ans),
        .out_opt   (out_opt),
        .out_zero  (out_zero),
        .out_sign  (out_sign),
        .count     (count)
    );

    // Clock generator, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LU_RESULT_FLAGS_EN
    localparam logic FLAGS_ON = 1'b1;
`else
    localparam logic FLAGS_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] a, input logic [2:0] o);
        in_valid = 1'b1;
        in_ans   = a;
        in_opt   = o;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] a);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_ans"}, 64'(out_ans), 64'(a));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [31:0] fill_a [4];
    logic [31:0] stream_q [$];

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;          // must be ignored while in reset
        in_ans    = 32'h1234_5678;
        in_opt    = 3'd5;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // First push, accepted on the first edge with rst_n=1
        rst_n  = 1'b1;
        in_ans = 32'h0110_0000;
        in_opt = 3'b000;
        tick();
        in_valid = 1'b0;
        check("p1_valid", 64'(out_valid), 64'd1);
        check("p1_ans", 64'(out_ans), 64'h0110_0000);
        check("p1_opt", 64'(out_opt), 64'd0);
        check("p1_zero", 64'(out_zero), 64'd0);
        check("p1_sign", 64'(out_sign), 64'd0);
        check("p1_count", 64'(count), 64'd1);
        pop_expect("p1_pop", 32'h0110_0000);
        check("p1_empty_count", 64'(count), 64'd0);
        check("p1_empty_valid", 64'(out_valid), 64'd0);

        // Empty: out_ready ignored
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("empty_pop_count", 64'(count), 64'd0);

        // Fill to full, drop 5th, drain in order
        fill_a[0] = 32'hA000_0001;
        fill_a[1] = 32'hA000_0002;
        fill_a[2] = 32'hA000_0003;
        fill_a[3] = 32'hA000_0004;
        for (int i = 0; i < 4; i++) begin
            push_one(fill_a[i], 3'(i + 1));
            check("fill_count", 64'(count), 64'(i + 1));
        end
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_head_opt", 64'(out_opt), 64'd1);
        push_one(32'hDEAD_BEEF, 3'd7);
        check("drop_count", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            pop_expect("drain", fill_a[i]);
        end
        check("drain_count", 64'(count), 64'd0);

        // Full with push+pop in the same cycle: only the pop happens
        fill_a[0] = 32'hB000_0001;
        fill_a[1] = 32'hB000_0002;
        fill_a[2] = 32'hB000_0003;
        fill_a[3] = 32'hB000_0004;
        for (int i = 0; i < 4; i++) begin
            push_one(fill_a[i], 3'd2);
        end
        in_valid  = 1'b1;
        in_ans    = 32'hCAFE_0001;
        in_opt    = 3'd3;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("fullpp_count", 64'(count), 64'd3);
        check("fullpp_head", 64'(out_ans), 64'hB000_0002);
        check("fullpp_in_ready", 64'(in_ready), 64'd1);
        tick();                    // in_valid still high: accepted now
        in_valid = 1'b0;
        check("fullpp_next_count", 64'(count), 64'd4);
        pop_expect("fullpp_d1", 32'hB000_0002);
        pop_expect("fullpp_d2", 32'hB000_0003);
        pop_expect("fullpp_d3", 32'hB000_0004);
        check("fullpp_d4_opt", 64'(out_opt), 64'd3);
        pop_expect("fullpp_d4", 32'hCAFE_0001);

        // Streaming at count=2 for 10 cycles (pointers wrap)
        stream_q.delete();
        for (int i = 0; i < 2; i++) begin
            stream_q.push_back(32'h1000_0000 + 32'(i));
            push_one(32'h1000_0000 + 32'(i), 3'd4);
        end
        for (int i = 2; i < 12; i++) begin
            check("stream_head", 64'(out_ans), 64'(stream_q[0]));
            void'(stream_q.pop_front());
            stream_q.push_back(32'h1000_0000 + 32'(i));
            in_valid  = 1'b1;
            in_ans    = 32'h1000_0000 + 32'(i);
            out_ready = 1'b1;
            tick();
            check("stream_count", 64'(count), 64'd2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pop_expect("stream_tail0", 32'h1000_000A);
        pop_expect("stream_tail1", 32'h1000_000B);

        // Flags
        push_one(32'h0000_0000, 3'd1);
        push_one(32'hBEE0_0000, 3'd1);
        check("flag_zero0", 64'(out_zero), 64'(FLAGS_ON));
        check("flag_sign0", 64'(out_sign), 64'd0);
        pop_expect("flag_pop0", 32'h0000_0000);
        check("flag_zero1", 64'(out_zero), 64'd0);
        check("flag_sign1", 64'(out_sign), 64'(FLAGS_ON));
        pop_expect("flag_pop1", 32'hBEE0_0000);

        // Asynchronous reset with count=3
        push_one(32'h5000_0001, 3'd0);
        push_one(32'h5000_0002, 3'd0);
        push_one(32'h5000_0003, 3'd0);
        check("prerst_count", 64'(count), 64'd3);
        #2;                        // mid-cycle, away from any edge
        rst_n = 1'b0;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        push_one(32'h6000_0001, 3'd6);
        check("postrst_count", 64'(count), 64'd1);
        check("postrst_ans", 64'(out_ans), 64'h6000_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lu_result_fifo.md
LU_RESULT_FIFO -- requirements
Module: lu_result_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of result entries; legal values are powers of two ≥ 2.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the logic-unit result width.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: the reset; it SHALL be asynchronous and active-low.
REQ-005 Port in_valid, input, 1: the upstream logic unit presents a result this cycle.
REQ-006 Port in_ans, input, DATA_W: the logic-unit result word.
REQ-007 Port in_opt, input, 3: the operation code that produced in_ans.
REQ-008 Port in_ready, output, 1: the FIFO accepts a push this cycle.
REQ-009 Port out_valid, output, 1: the head entry is valid.
REQ-010 Port out_ready, input, 1: the downstream consumer takes the head entry this cycle.
REQ-011 Port out_ans, output, DATA_W: the head result word.
REQ-012 Port out_opt, output, 3: the head operation code.
REQ-013 Port out_zero, output, 1: the head result equals zero.
REQ-014 Port out_sign, output, 1: the head result MSB.
REQ-015 Port count, output, $clog2(DEPTH)+1: the number of stored entries.

Function
REQ-016 A push SHALL occur when in_valid && in_ready; {in_ans, in_opt, flags} are written to mem[wr_ptr] and wr_ptr increments.
REQ-017 A pop SHALL occur when out_valid && out_ready; rd_ptr increments.
REQ-018 in_ready SHALL equal (count != DEPTH), combinationally from registered count.
REQ-019 out_valid SHALL equal (count != 0); out_ans, out_opt, out_zero and out_sign SHALL be mem[rd_ptr] (first-word fall-through).
REQ-020 Latency: a word pushed at edge N SHALL appear on the outputs with out_valid=1 after edge N (one cycle); there is no same-cycle bypass.
REQ-021 Pointers SHALL wrap modulo DEPTH (DEPTH-1 -> 0) with no gap.
REQ-022 Push only: count+1. Pop only: count-1. Push and pop together: count unchanged and both pointers advance.
REQ-023 Full (count==DEPTH): in_ready=0 and in_valid is ignored even if a pop occurs in the same cycle; the freed slot is available next cycle.
REQ-024 Empty (count==0): out_valid=0 and out_ready is ignored; the output data value is don't-care.
REQ-025 Flags SHALL be computed at push time: zero = (in_ans == 0), sign = in_ans[DATA_W-1].
REQ-026 Stored entries SHALL NOT change while resident; only the head pointer moves.

Reset
REQ-027 While rst_n=0: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=1; pushes are ignored.
REQ-028 Reset asserted mid-operation SHALL immediately discard all entries; memory contents need no reset.
REQ-029 The first push SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-030 Macro LU_RESULT_FLAGS_EN: when defined, the flag storage and out_zero/out_sign SHALL behave as in REQ-025.
REQ-031 Without LU_RESULT_FLAGS_EN, no flag storage SHALL be built and out_zero=out_sign=0 constantly; all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then push in_ans=0x01100000, opt=000 -> next cycle out_valid=1, out_ans=0x01100000, out_zero=0, out_sign=0, count=1.
REQ-033 Push 4 words with out_ready=0 -> count=4, in_ready=0; a 5th push (0xDEADBEEF) is dropped, and pops return the first 4 in order.
REQ-034 Full FIFO, in_valid=1 and out_ready=1 in the same cycle -> pop only, count=3; the next cycle's push is accepted.
REQ-035 Continuous push and pop at count=2 for 10 cycles -> count stays 2, pointers wrap, and output order matches input order.
REQ-036 Push 0x00000000 then 0xBEE00000 -> out_zero=1 then out_sign=1 (both 0 when built without LU_RESULT_FLAGS_EN).
REQ-037 rst_n pulsed low with count=3 -> out_valid=0 and count=0 immediately, without waiting for a clock edge.
